// File: rtl/sparhixcel_output_engine.sv
// sparhixcel_output_engine: accumulates systolic-array column results over
// channel rounds into a per-filter/per-position buffer, then drains every
// live filter/position as a saturated valid/ready stream.
// Optional macro SPARHIXCEL_OUT_RELU_EN: apply ReLU on the drain path.
module sparhixcel_output_engine #(
  parameter int N_COLS_ARRAY             = 16,
  parameter int I_WIDTH                  = 8,
  parameter int F_WIDTH                  = 8,
  parameter int ACC_WIDTH                = 24,
  parameter int NUMBER_SUPPORTED_FILTERS = 30,
  parameter int DEPTH                    = 64,
  parameter int MAX_ROUNDS               = 8,
  localparam int N_GROUPS  = (NUMBER_SUPPORTED_FILTERS + N_COLS_ARRAY - 1) / N_COLS_ARRAY,
  localparam int OUT_WIDTH = I_WIDTH + F_WIDTH,
  localparam int RW  = $clog2(MAX_ROUNDS + 1),
  localparam int PW  = $clog2(DEPTH + 1),
  localparam int GW  = $clog2(N_GROUPS + 1),
  localparam int FW  = $clog2(NUMBER_SUPPORTED_FILTERS),
  localparam int OPW = $clog2(DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           general_rst_ni,
  input  logic                           start_i,
  input  logic [RW-1:0]                  n_rounds_i,
  input  logic [PW-1:0]                  n_positions_i,
  input  logic [GW-1:0]                  n_groups_i,
  input  logic                           abort_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [N_COLS_ARRAY*OUT_WIDTH-1:0] in_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [OUT_WIDTH-1:0]           out_data_o,
  output logic [FW-1:0]                  out_filter_o,
  output logic [OPW-1:0]                 out_pos_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           cfg_err_o
);
  localparam int CW = (N_COLS_ARRAY > 1) ? $clog2(N_COLS_ARRAY) : 1;
  localparam int AW = $clog2(N_GROUPS * DEPTH);

  localparam logic signed [ACC_WIDTH:0]   AMAX_X = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0]   AMIN_X = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OMAX_X = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OMIN_X = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_e;

  // Saturating accumulate at signed ACC_WIDTH bounds.
  function automatic logic signed [ACC_WIDTH-1:0] acc_sat(
    input logic signed [ACC_WIDTH-1:0] a, input logic signed [OUT_WIDTH-1:0] b);
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    if (s > AMAX_X)      acc_sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else if (s < AMIN_X) acc_sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else                 acc_sat = s[ACC_WIDTH-1:0];
  endfunction

  // Clamp an accumulator to the signed output width.
  function automatic logic signed [OUT_WIDTH-1:0] out_sat(input logic signed [ACC_WIDTH-1:0] v);
    if (v > OMAX_X)      out_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (v < OMIN_X) out_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                 out_sat = v[OUT_WIDTH-1:0];
  endfunction

  // Column c of group g lives in mem_q[c][g*DEPTH + pos] (filter g*N_COLS+c).
  logic signed [ACC_WIDTH-1:0] mem_q [N_COLS_ARRAY][N_GROUPS*DEPTH];

  state_e         state_q, state_d;
  logic [RW-1:0]  cfg_rnd_q, cfg_rnd_d, rnd_cnt_q, rnd_cnt_d;
  logic [PW-1:0]  cfg_pos_q, cfg_pos_d, pos_cnt_q, pos_cnt_d, drn_pos_q, drn_pos_d;
  logic [GW-1:0]  cfg_grp_q, cfg_grp_d, grp_cnt_q, grp_cnt_d, drn_grp_q, drn_grp_d;
  logic [FW-1:0]  drn_f_q, drn_f_d;
  logic [CW-1:0]  drn_col_q, drn_col_d;
  logic           oval_q, oval_d, done_q, done_d, cerr_q, cerr_d;
  logic signed [ACC_WIDTH-1:0] rd_q;
  logic           acc_fire, cfg_ok;
  logic [AW-1:0]  acc_addr, rd_addr;
  int             n_filt;

  assign cfg_ok = (n_rounds_i != '0) && (n_positions_i != '0) && (n_groups_i != '0) &&
                  (int'(n_rounds_i) <= MAX_ROUNDS) && (int'(n_positions_i) <= DEPTH) &&
                  (int'(n_groups_i) <= N_GROUPS);
  assign n_filt   = (int'(cfg_grp_q) * N_COLS_ARRAY > NUMBER_SUPPORTED_FILTERS) ?
                    NUMBER_SUPPORTED_FILTERS : int'(cfg_grp_q) * N_COLS_ARRAY;
  assign acc_addr = AW'(int'(grp_cnt_q) * DEPTH + int'(pos_cnt_q));
  // Read address follows the next-state drain counters so data lines up with them.
  assign rd_addr  = AW'(int'(drn_grp_d) * DEPTH + int'(drn_pos_d));

  // Next-state: config latch, beat sequencing, drain sequencing, pulses.
  always_comb begin
    state_d   = state_q;
    cfg_rnd_d = cfg_rnd_q;  cfg_pos_d = cfg_pos_q;  cfg_grp_d = cfg_grp_q;
    rnd_cnt_d = rnd_cnt_q;  pos_cnt_d = pos_cnt_q;  grp_cnt_d = grp_cnt_q;
    drn_pos_d = drn_pos_q;  drn_grp_d = drn_grp_q;  drn_f_d   = drn_f_q;
    drn_col_d = drn_col_q;
    oval_d    = oval_q;
    done_d    = 1'b0;
    cerr_d    = 1'b0;
    acc_fire  = 1'b0;
    if (abort_i) begin
      state_d   = S_IDLE;
      rnd_cnt_d = '0;  pos_cnt_d = '0;  grp_cnt_d = '0;
      drn_pos_d = '0;  drn_grp_d = '0;  drn_f_d   = '0;  drn_col_d = '0;
      oval_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) begin
          if (cfg_ok) begin
            cfg_rnd_d = n_rounds_i;  cfg_pos_d = n_positions_i;  cfg_grp_d = n_groups_i;
            rnd_cnt_d = '0;  pos_cnt_d = '0;  grp_cnt_d = '0;
            state_d   = S_ACCUM;
          end else begin
            cerr_d = 1'b1;
          end
        end
        S_ACCUM: if (in_valid_i) begin
          acc_fire = 1'b1;
          if (pos_cnt_q == cfg_pos_q - PW'(1)) begin
            pos_cnt_d = '0;
            if (grp_cnt_q == cfg_grp_q - GW'(1)) begin
              grp_cnt_d = '0;
              if (rnd_cnt_q == cfg_rnd_q - RW'(1)) begin
                rnd_cnt_d = '0;
                state_d   = S_DRAIN;
                drn_pos_d = '0;  drn_grp_d = '0;  drn_f_d = '0;  drn_col_d = '0;
              end else begin
                rnd_cnt_d = rnd_cnt_q + RW'(1);
              end
            end else begin
              grp_cnt_d = grp_cnt_q + GW'(1);
            end
          end else begin
            pos_cnt_d = pos_cnt_q + PW'(1);
          end
        end
        S_DRAIN: begin
          if (!oval_q) begin
            oval_d = 1'b1;  // first cycle covers the buffer read latency
          end else if (out_ready_i) begin
            if (drn_pos_q == cfg_pos_q - PW'(1)) begin
              if (int'(drn_f_q) == n_filt - 1) begin
                state_d   = S_IDLE;
                oval_d    = 1'b0;
                done_d    = 1'b1;
                drn_pos_d = '0;  drn_grp_d = '0;  drn_f_d = '0;  drn_col_d = '0;
              end else begin
                drn_pos_d = '0;
                drn_f_d   = drn_f_q + FW'(1);
                if (drn_col_q == CW'(N_COLS_ARRAY - 1)) begin
                  drn_col_d = '0;
                  drn_grp_d = drn_grp_q + GW'(1);
                end else begin
                  drn_col_d = drn_col_q + CW'(1);
                end
              end
            end else begin
              drn_pos_d = drn_pos_q + PW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and control registers.
  always_ff @(posedge clk_i or negedge general_rst_ni) begin
    if (!general_rst_ni) begin
      state_q   <= S_IDLE;
      cfg_rnd_q <= '0;  cfg_pos_q <= '0;  cfg_grp_q <= '0;
      rnd_cnt_q <= '0;  pos_cnt_q <= '0;  grp_cnt_q <= '0;
      drn_pos_q <= '0;  drn_grp_q <= '0;  drn_f_q   <= '0;  drn_col_q <= '0;
      oval_q    <= 1'b0;  done_q <= 1'b0;  cerr_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cfg_rnd_q <= cfg_rnd_d;  cfg_pos_q <= cfg_pos_d;  cfg_grp_q <= cfg_grp_d;
      rnd_cnt_q <= rnd_cnt_d;  pos_cnt_q <= pos_cnt_d;  grp_cnt_q <= grp_cnt_d;
      drn_pos_q <= drn_pos_d;  drn_grp_q <= drn_grp_d;  drn_f_q   <= drn_f_d;
      drn_col_q <= drn_col_d;
      oval_q    <= oval_d;  done_q <= done_d;  cerr_q <= cerr_d;
      rd_q      <= oval_d ? mem_q[drn_col_d][rd_addr] : '0;
    end
  end

  // Buffer update; round 0 restarts each sum, dead filter slots are dropped.
  always_ff @(posedge clk_i) begin
    if (acc_fire && !abort_i) begin
      for (int c = 0; c < N_COLS_ARRAY; c++) begin
        if (int'(grp_cnt_q) * N_COLS_ARRAY + c < NUMBER_SUPPORTED_FILTERS)
          mem_q[c][acc_addr] <= acc_sat((rnd_cnt_q == '0) ? '0 : mem_q[c][acc_addr],
                                        in_data_i[c*OUT_WIDTH +: OUT_WIDTH]);
      end
    end
  end

  logic signed [OUT_WIDTH-1:0] sat_v;
  assign sat_v = out_sat(rd_q);
`ifdef SPARHIXCEL_OUT_RELU_EN
  assign out_data_o = sat_v[OUT_WIDTH-1] ? '0 : sat_v;
`else
  assign out_data_o = sat_v;
`endif
  assign in_ready_o   = (state_q == S_ACCUM);
  assign out_valid_o  = oval_q;
  assign out_filter_o = drn_f_q;
  assign out_pos_o    = OPW'(drn_pos_q);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign cfg_err_o    = cerr_q;
endmodule

// File: tb/tb_sparhixcel_output_engine.sv
// Scoreboard bench for sparhixcel_output_engine (default parameters).
module tb_sparhixcel_output_engine;
  localparam int NC = 16, OW = 16, NSF = 30, DP = 64;

  logic clk = 1'b0, rst_n;
  logic start, abort, in_valid, in_ready, out_valid, out_ready, busy, done, cfg_err;
  logic [3:0] n_rounds;
  logic [6:0] n_pos;
  logic [1:0] n_groups;
  logic [NC*OW-1:0] in_data;
  logic [OW-1:0] out_data;
  logic [4:0] out_filter;
  logic [5:0] out_pos;

  typedef struct { int f; int p; int d; } exp_t;
  exp_t   sbq[$];
  longint mdl [NSF][DP];
  int     n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  sparhixcel_output_engine dut (
    .clk_i(clk), .general_rst_ni(rst_n), .start_i(start), .n_rounds_i(n_rounds),
    .n_positions_i(n_pos), .n_groups_i(n_groups), .abort_i(abort),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_filter_o(out_filter), .out_pos_o(out_pos), .busy_o(busy),
    .done_o(done), .cfg_err_o(cfg_err));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clampw(input longint v, input int w);
    longint mx = (64'sd1 <<< (w - 1)) - 1;
    longint mn = -(64'sd1 <<< (w - 1));
    return (v > mx) ? mx : (v < mn) ? mn : v;
  endfunction

  function automatic int colval(input int mode, input int r, input int g, input int p, input int c);
    case (mode)
      0: return (p == 0) ? c + 1 : -(c + 1);
      1: return 100;
      2: return 5;
      3: return 7;
      4: return 32767;
      5: return -32768;
      default: return ((r * 7 + g * 3 + p * 5 + c * 11) % 200) - 100;
    endcase
  endfunction

  function automatic logic [NC*OW-1:0] mkvec(input int mode, input int r, input int g, input int p);
    logic [NC*OW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*OW +: OW] = 16'(colval(mode, r, g, p, c));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int nr, input int np, input int ng);
    n_rounds = 4'(nr); n_pos = 7'(np); n_groups = 2'(ng);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_beat(input logic [NC*OW-1:0] v);
    int budget = 0;
    in_valid = 1'b1; in_data = v;
    @(negedge clk);
    while (!in_ready && budget < 100) begin
      budget++; tick(); @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // rmode: 0 ready held high, 1 ready toggles 1010.., 2 random ready.
  task automatic drain(input int rmode);
    int cyc = 0, dones = 0;
    logic pv = 1'b0, pr = 1'b1, seen = 1'b0;
    logic [OW-1:0] pd = '0; logic [4:0] pf = '0; logic [5:0] pp = '0;
    exp_t e;
    while (sbq.size() > 0 && cyc < 5000) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      @(negedge clk); cyc++;
      if (done) dones++;
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_filter", out_filter, pf);
        chk("stall_pos", out_pos, pp);
      end
      if (rmode == 0 && seen) chk("throughput", out_valid, 1);
      if (out_valid) begin
        seen = 1'b1;
        if (out_ready) begin
          e = sbq.pop_front();
          chk("out_data", longint'($signed(out_data)), e.d);
          chk("out_filter", out_filter, e.f);
          chk("out_pos", out_pos, e.p);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pf = out_filter; pp = out_pos;
      tick();
    end
    if (sbq.size() > 0) begin
      chk("drain_timeout_left", sbq.size(), 0);
      sbq.delete();
    end
    chk("done_early", dones, 0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("valid_after_last", out_valid, 0);
    tick(); @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    tick();
  endtask

  task automatic do_job(input int nr, input int np, input int ng, input int mode, input int rmode);
    int nf;
    longint d;
    exp_t e;
    start_job(nr, np, ng);
    @(negedge clk); chk("busy_start", busy, 1); tick();
    for (int r = 0; r < nr; r++)
      for (int g = 0; g < ng; g++)
        for (int p = 0; p < np; p++) begin
          for (int c = 0; c < NC; c++)
            if (g * NC + c < NSF)
              mdl[g*NC+c][p] = clampw(((r == 0) ? 0 : mdl[g*NC+c][p]) + colval(mode, r, g, p, c), 24);
          send_beat(mkvec(mode, r, g, p));
        end
    @(negedge clk); chk("in_ready_drop", in_ready, 0); tick();
    nf = (ng * NC > NSF) ? NSF : ng * NC;
    for (int f = 0; f < nf; f++)
      for (int p = 0; p < np; p++) begin
        d = clampw(mdl[f][p], 16);
`ifdef SPARHIXCEL_OUT_RELU_EN
        if (d < 0) d = 0;
`endif
        e.f = f; e.p = p; e.d = int'(d);
        sbq.push_back(e);
      end
    drain(rmode);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_rounds = '0; n_pos = '0; n_groups = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_filter", out_filter, 0);
    chk("rst_out_pos", out_pos, 0);
    tick(); rst_n = 1'b1; tick();

    do_job(1, 2, 1, 0, 0);   // f pos0 = f+1, pos1 = -(f+1)
    do_job(3, 1, 1, 1, 0);   // 300
    do_job(1, 1, 1, 2, 0);   // round 0 clears old sums -> 5
    do_job(1, 1, 2, 3, 0);   // 30 filters only
    do_job(4, 1, 1, 4, 0);   // positive saturation
    do_job(4, 1, 1, 5, 0);   // negative saturation (or ReLU 0)
    do_job(2, 3, 2, 6, 1);   // toggling ready
    do_job(1, 4, 1, 6, 0);   // full-rate drain
    do_job(2, 2, 2, 6, 2);   // random ready

    // Rejected configurations.
    start_job(1, 0, 1);
    @(negedge clk); chk("cfg_err_pos0", cfg_err, 1); chk("cfg_err_busy", busy, 0);
    tick(); @(negedge clk); chk("cfg_err_clear", cfg_err, 0); tick();
    start_job(9, 1, 1);
    @(negedge clk); chk("cfg_err_rounds", cfg_err, 1); chk("cfg_err_busy2", busy, 0); tick();

    // in_valid while idle is ignored.
    in_valid = 1'b1; in_data = mkvec(3, 0, 0, 0);
    repeat (3) tick();
    @(negedge clk); chk("idle_in_ready", in_ready, 0); chk("idle_busy", busy, 0);
    tick(); in_valid = 1'b0;

    // Abort mid-accumulation.
    start_job(2, 3, 1);
    send_beat(mkvec(3, 0, 0, 0));
    send_beat(mkvec(3, 0, 0, 1));
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk); chk("abort_busy", busy, 0); chk("abort_in_ready", in_ready, 0);
    budget = 0;
    repeat (6) begin
      tick(); @(negedge clk);
      if (done || out_valid) budget++;
    end
    chk("abort_no_done", budget, 0);
    tick();
    do_job(1, 1, 1, 2, 0);   // recovery after abort

    // Reset in the middle of a drain.
    start_job(1, 1, 1);
    send_beat(mkvec(3, 0, 0, 0));
    out_ready = 1'b0;
    budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 20) begin budget++; tick(); @(negedge clk); end
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("reset_drain_valid", out_valid, 0);
    chk("reset_drain_busy", busy, 0);
    tick(); rst_n = 1'b1; tick();
    do_job(1, 2, 1, 0, 2);   // recovery after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
